// File: rtl/adder_8bit.sv
// Registered ripple-carry adder: {cout,sum} = a + b + cin, one cycle latency.
// Define ADDER_8BIT_OVF_EN to add the registered signed-overflow output ovf.
module adder_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_8BIT_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    // Explicit full-adder chain; c[i+1] depends only on bit i and c[i].
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

`ifdef ADDER_8BIT_OVF_EN
    logic ovf_d;

    always_comb begin
        ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
`ifdef ADDER_8BIT_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            sum  <= s;
            cout <= c[WIDTH];
`ifdef ADDER_8BIT_OVF_EN
            ovf  <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_adder_8bit.sv
// Scoreboard bench for adder_8bit: driver queues expected {ovf,cout,sum},
// monitor pops and compares one period later.
module tb_adder_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf_w;

`ifdef ADDER_8BIT_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
    assign ovf_w = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [9:0] q[$];

    adder_8bit #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
`ifdef ADDER_8BIT_OVF_EN
        ,
        .ovf  (ovf_w)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [9:0] act,
                       input logic [9:0] exp);
        logic [9:0] m;
        m = {OVF, 9'h1ff};
        total++;
        if ((act & m) !== (exp & m)) begin
            bad++;
            $display("FAIL %s: got ovf=%0b cout=%0b sum=%02h, want ovf=%0b cout=%0b sum=%02h",
                     name, act[9], act[8], act[7:0], exp[9] & OVF, exp[8], exp[7:0]);
        end
    endtask

    // Drive mid-cycle (falling edge) and queue the result for the next rising edge.
    task automatic drive(input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, input logic [9:0] exp);
        @(negedge clk);
        a   = va;
        b   = vb;
        cin = vc;
        q.push_back(exp);
    endtask

    // Monitor: results are valid one time unit after every rising edge.
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                chk("result", {ovf_w, cout, sum}, e);
            end
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [9:0] exp;
    } vec_t;

    vec_t dir[$];

    initial begin
        logic [8:0] t;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic       ro;

        // {ovf, cout, sum}
        dir.push_back('{8'hFF, 8'hFF, 1'b1, {1'b0, 1'b1, 8'hFF}});
        dir.push_back('{8'hFF, 8'h00, 1'b1, {1'b0, 1'b1, 8'h00}});
        dir.push_back('{8'h00, 8'h00, 1'b0, {1'b0, 1'b0, 8'h00}});
        dir.push_back('{8'h0F, 8'h01, 1'b0, {1'b0, 1'b0, 8'h10}});
        dir.push_back('{8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80}});
        dir.push_back('{8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00}});
        dir.push_back('{8'h55, 8'hAA, 1'b0, {1'b0, 1'b0, 8'hFF}});
        dir.push_back('{8'h3C, 8'hC3, 1'b1, {1'b0, 1'b1, 8'h00}});
        dir.push_back('{8'h12, 8'h34, 1'b1, {1'b0, 1'b0, 8'h47}});

        // Reset asserted before any clock edge
        rst_n = 1'b0;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
        #1;
        chk("reset_initial", {ovf_w, cout, sum}, 10'h000);

        // Release mid-cycle; AA+55+1 = 0x100
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back({1'b0, 1'b1, 8'h00});

        foreach (dir[i])
            drive(dir[i].a, dir[i].b, dir[i].c, dir[i].exp);

        // Latency: input change after the edge must not reach the outputs
        drive(8'h01, 8'h00, 1'b0, {1'b0, 1'b0, 8'h01});
        @(posedge clk);
        #3;
        a = 8'h02;
        chk("latency_hold", {ovf_w, cout, sum}, {1'b0, 1'b0, 8'h01});
        q.push_back({1'b0, 1'b0, 8'h02});
        @(posedge clk);

        // Random regression
        for (int i = 0; i < 10000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            t  = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            ro = (ra[7] == rb[7]) && (t[7] != ra[7]);
            drive(ra, rb, rc, {ro, t});
        end

        // Reset mid-stream with a pending (unqueued) operation
        @(negedge clk);
        a   = 8'hFF;
        b   = 8'hFF;
        cin = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_reset", {ovf_w, cout, sum}, {1'b0, 1'b1, 8'hFF});
        a   = 8'h7F;
        b   = 8'h7F;
        cin = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_clear", {ovf_w, cout, sum}, 10'h000);
        @(posedge clk);
        #1;
        chk("reset_hold", {ovf_w, cout, sum}, 10'h000);

        @(negedge clk);
        rst_n = 1'b1;
        q.push_back({1'b1, 1'b0, 8'hFF});
        drive(8'h20, 8'h22, 1'b0, {1'b0, 1'b0, 8'h42});

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d queued, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
